multicycle_ctrl_hs: RTL
=======================

Name: multicycle_ctrl_hs

Overview:
- Next-generation multicycle CPU control FSM. It sequences fetch, decode, execute, memory and writeback, and drives every datapath select and enable.
- Adds over the current controller: a ready/valid-style memory handshake with variable wait states, a watchdog timeout to a sticky fault, a single level-sensitive interrupt taken at instruction boundaries, and parametrised PSR width.
- Sits between the instruction register / PSR and the datapath muxes, register file, PC and memory port.

Parameters:
- PSR_W, 5, width of PSR input; flag bit positions come from the shared package.
- MEM_TIMEOUT, 15, maximum cycles a memory state waits for mem_ready before faulting (1..255).
- INT_EN, 1, 1 = interrupt logic present; 0 = irq ignored and IRQ states unreachable.
- LINK_REG, 15, register index written with the return PC on interrupt entry.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- op  in  4  instruction opcode
- op_ext  in  4  opcode extension
- branch_cond  in  4  condition field
- PSR  in  PSR_W  processor status flags
- mem_ready  in  1  memory completes the current access this cycle
- irq  in  1  level interrupt request
- WD_S  out  2  write-data select: 00 rsrc, 01 PC, 10 mem, 11 ALU reg
- ALUA_S, ALUB_S  out  2 each  ALU operand selects, same codes as the current datapath
- PC_S  out  2  PC source: 00 register, 01 ALU, 10 IRQ vector
- PC_EN, REG_WR_EN, INSTR_EN, ALU_OUT_EN, MEM_REG_EN, MEM_WR_S, MEM_S, SE_SIGN, PSR_EN  out  1 each  as in the current datapath
- wr_link  out  1  forces the register-file write address to LINK_REG
- mem_req  out  1  memory access request
- irq_ack  out  1  one-cycle pulse on interrupt vector load
- in_isr  out  1  interrupt service in progress
- fault  out  1  sticky memory-timeout fault

Behaviour:
- Outputs are a combinational Moore decode of state, except that INSTR_EN, MEM_REG_EN and MEM_WR_S are qualified by mem_ready.
- Default output values: all 0, except SE_SIGN=1.
- Reset: state=FETCH, wait_cnt=0, in_isr=0, fault=0. Reset mid-access abandons the access with no further handshake.
- States, with transitions and asserted outputs:
  - FETCH: MEM_S=1, mem_req=1, INSTR_EN=mem_ready. Goes to DECODE on mem_ready, else stays.
  - DECODE: dispatches exactly as today.
    - op=0100: op_ext 0100 -> ST_MEM; 0000 -> LD_MEM; 1100 -> JUMP if taken else PC_UP; 1000 -> CALC_RLINK; any other op_ext -> FAULT.
    - op=0000 -> RTYPE_EX.
    - op=1100 -> CALC_DISP if taken else PC_UP.
    - Any other op -> ITYPE_EX.
  - RTYPE_EX: ALU_OUT_EN=1, PSR_EN=1. Goes to PC_UP if op_ext=1011 (CMP), else WRITE.
  - ITYPE_EX: ALUA_S=10, ALU_OUT_EN=1, PSR_EN=1; SE_SIGN=0 for op 0001/0010/0011. Goes to PC_UP if op=1011, else WRITE.
  - WRITE: WD_S=11, REG_WR_EN=1. Goes to PC_UP.
  - LD_MEM: mem_req=1, MEM_REG_EN=mem_ready. Holds until mem_ready, then goes to LD_WB.
  - LD_WB: WD_S=10, REG_WR_EN=1. Goes to PC_UP.
  - ST_MEM: mem_req=1, MEM_WR_S=mem_ready. Holds until mem_ready, then goes to PC_UP.
  - CALC_DISP: ALUA_S=01, ALUB_S=01, PC_S=01, PC_EN=1.
  - JUMP: PC_S=00, PC_EN=1; clears in_isr.
  - CALC_RLINK: ALUA_S=01, ALUB_S=10, ALU_OUT_EN=1. Goes to WR_RLINK_J.
  - WR_RLINK_J: WD_S=11, REG_WR_EN=1, PC_EN=1.
  - PC_UP: ALUA_S=01, ALUB_S=10, PC_S=01, PC_EN=1.
  - IRQ_SAVE: WD_S=01, wr_link=1, REG_WR_EN=1. Goes to IRQ_VEC.
  - IRQ_VEC: PC_S=10, PC_EN=1, irq_ack=1; sets in_isr. Goes to FETCH.
  - FAULT: all outputs default, fault=1. Exits only via reset.
- Instruction boundary: the states PC_UP, CALC_DISP, JUMP and WR_RLINK_J. At a boundary, next state is IRQ_SAVE if INT_EN && irq && !in_isr, else FETCH.
  - Because the PC is already updated at the boundary, the saved PC is the next instruction.
  - If irq asserts during JUMP, in_isr is cleared that cycle, so the interrupt is taken immediately.
- Branch taken: computed by a combinational evaluator from branch_cond and PSR. The PSR value used is the one sampled in DECODE.
- Wait counter:
  - wait_cnt is 8 bits. It clears on entry to FETCH, LD_MEM or ST_MEM and increments each cycle the FSM stays there.
  - If wait_cnt reaches MEM_TIMEOUT with mem_ready still low, the next state is FAULT.
  - mem_ready arriving in the same cycle as the limit wins, and the access completes.
- Illegal state encodings go to FAULT.

Decomposition:
- Package ctrl_pkg holds:
  - state encoding (5-bit enum);
  - opcode and op_ext constants (RTYPE, OP_EXT, BCOND, LB, SB, JCOND, JAL, CMP, ANDI, ORI, XORI, MOVI);
  - select codes for WD_S, ALU operands and PC_S;
  - PSR bit indices (C, L, F, Z, N).
- One sub-module, branch_cond_eval: purely combinational mapping of (branch_cond, PSR) to taken, per the ISA condition table.

Test Plan:
- Reset high 2 cycles, then low, mem_ready=1 -> state=FETCH, mem_req=1, INSTR_EN=1; all other outputs at defaults, SE_SIGN=1.
- ADD (op=0000, op_ext=0101), mem_ready=1 -> FETCH, DECODE, RTYPE_EX, WRITE, PC_UP, FETCH: 5 cycles, REG_WR_EN high only in WRITE. CMP (op_ext=1011) -> 4 cycles, no REG_WR_EN.
- LOAD with mem_ready delayed 3 cycles in LD_MEM -> mem_req held 4 cycles, MEM_REG_EN high on the 4th only, then LD_WB asserts WD_S=10.
- MEM_TIMEOUT=15, mem_ready stuck low in FETCH -> FAULT entered after 15 wait cycles, fault=1 persists for 100 cycles, cleared only by reset.
- irq=1 during ANDI (op=0001) -> SE_SIGN=0 in ITYPE_EX; after PC_UP comes IRQ_SAVE (wr_link=1, WD_S=01), then IRQ_VEC (PC_S=10, irq_ack one cycle), in_isr=1; irq held high causes no re-entry until a taken JCOND JUMP.
- Bcond with condition false (Z=0 for EQ) -> DECODE to PC_UP; with Z=1 -> CALC_DISP with PC_S=01, ALUB_S=01.

Source files
------------

// File: rtl/multicycle_ctrl_hs_pkg.sv
// Shared definitions for the multicycle control FSM: state encoding, ISA
// opcode constants, datapath select codes and PSR flag positions.
package ctrl_pkg;

    typedef enum logic [4:0] {
        S_FETCH      = 5'd0,
        S_DECODE     = 5'd1,
        S_RTYPE_EX   = 5'd2,
        S_ITYPE_EX   = 5'd3,
        S_WRITE      = 5'd4,
        S_LD_MEM     = 5'd5,
        S_LD_WB      = 5'd6,
        S_ST_MEM     = 5'd7,
        S_CALC_DISP  = 5'd8,
        S_JUMP       = 5'd9,
        S_CALC_RLINK = 5'd10,
        S_WR_RLINK_J = 5'd11,
        S_PC_UP      = 5'd12,
        S_IRQ_SAVE   = 5'd13,
        S_IRQ_VEC    = 5'd14,
        S_FAULT      = 5'd15
    } state_t;

    localparam logic [3:0] RTYPE  = 4'b0000;
    localparam logic [3:0] OP_EXT = 4'b0100;
    localparam logic [3:0] BCOND  = 4'b1100;
    localparam logic [3:0] CMP    = 4'b1011;
    localparam logic [3:0] ANDI   = 4'b0001;
    localparam logic [3:0] ORI    = 4'b0010;
    localparam logic [3:0] XORI   = 4'b0011;
    localparam logic [3:0] MOVI   = 4'b1101;

    localparam logic [3:0] LB     = 4'b0000;
    localparam logic [3:0] SB     = 4'b0100;
    localparam logic [3:0] JCOND  = 4'b1100;
    localparam logic [3:0] JAL    = 4'b1000;

    localparam logic [1:0] WD_RSRC = 2'b00;
    localparam logic [1:0] WD_PC   = 2'b01;
    localparam logic [1:0] WD_MEM  = 2'b10;
    localparam logic [1:0] WD_ALU  = 2'b11;

    localparam logic [1:0] ALUA_REG = 2'b00;
    localparam logic [1:0] ALUA_PC  = 2'b01;
    localparam logic [1:0] ALUA_IMM = 2'b10;

    localparam logic [1:0] ALUB_REG  = 2'b00;
    localparam logic [1:0] ALUB_DISP = 2'b01;
    localparam logic [1:0] ALUB_ONE  = 2'b10;

    localparam logic [1:0] PC_SRC_REG = 2'b00;
    localparam logic [1:0] PC_SRC_ALU = 2'b01;
    localparam logic [1:0] PC_SRC_VEC = 2'b10;

    localparam int PSR_C = 0;
    localparam int PSR_L = 1;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 3;
    localparam int PSR_N = 4;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_LD_MEM) || (s == S_ST_MEM);
    endfunction

    // Logical immediates are zero-extended; everything else sign-extends.
    function automatic logic imm_sign_ext(input logic [3:0] opcode);
        return !((opcode == ANDI) || (opcode == ORI) || (opcode == XORI));
    endfunction

endpackage

// File: rtl/multicycle_ctrl_hs_if.sv
// Memory ready/valid handshake plus interrupt request/acknowledge between the
// control FSM (master) and the memory/interrupt side (slave).
interface multicycle_ctrl_hs_if;
    logic mem_req;
    logic mem_ready;
    logic irq;
    logic irq_ack;

    modport master (output mem_req, output irq_ack, input mem_ready, input irq);
    modport slave  (input mem_req, input irq_ack, output mem_ready, output irq);
endinterface

// File: rtl/multicycle_ctrl_hs_branch_cond_eval.sv
// Combinational branch condition evaluator: maps the 4-bit condition field
// and the PSR flags to a taken/not-taken decision.
module branch_cond_eval
    import ctrl_pkg::*;
#(
    parameter int PSR_W = 5
) (
    input  logic [3:0]       branch_cond,
    input  logic [PSR_W-1:0] psr,
    output logic             taken
);

    logic flag_c, flag_l, flag_f, flag_z, flag_n;

    assign flag_c = psr[PSR_C];
    assign flag_l = psr[PSR_L];
    assign flag_f = psr[PSR_F];
    assign flag_z = psr[PSR_Z];
    assign flag_n = psr[PSR_N];

    always_comb begin
        taken = 1'b0;
        case (branch_cond)
            4'b0000: taken = flag_z;
            4'b0001: taken = !flag_z;
            4'b0010: taken = flag_c;
            4'b0011: taken = !flag_c;
            4'b0100: taken = flag_l;
            4'b0101: taken = !flag_l;
            4'b0110: taken = flag_n;
            4'b0111: taken = !flag_n;
            4'b1000: taken = flag_f;
            4'b1001: taken = !flag_f;
            4'b1010: taken = !flag_l && !flag_z;
            4'b1011: taken = flag_l || flag_z;
            4'b1100: taken = !flag_n && !flag_z;
            4'b1101: taken = flag_n || flag_z;
            4'b1110: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_hs.sv
// Multicycle CPU control FSM with a ready/valid memory handshake, memory
// watchdog to a sticky fault, and a single level interrupt at boundaries.
module multicycle_ctrl_hs
    import ctrl_pkg::*;
#(
    parameter int PSR_W       = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int INT_EN      = 1,
    parameter int LINK_REG    = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          op,
    input  logic [3:0]          op_ext,
    input  logic [3:0]          branch_cond,
    input  logic [PSR_W-1:0]    PSR,
    multicycle_ctrl_hs_if.master bus,
    output logic [1:0]          WD_S,
    output logic [1:0]          ALUA_S,
    output logic [1:0]          ALUB_S,
    output logic [1:0]          PC_S,
    output logic                PC_EN,
    output logic                REG_WR_EN,
    output logic                INSTR_EN,
    output logic                ALU_OUT_EN,
    output logic                MEM_REG_EN,
    output logic                MEM_WR_S,
    output logic                MEM_S,
    output logic                SE_SIGN,
    output logic                PSR_EN,
    output logic                wr_link,
    output logic                in_isr,
    output logic                fault
);

    localparam logic       IRQ_ON      = (INT_EN != 0);
    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic       taken;
    logic       timed_out;
    logic       irq_take;
    logic       irq_take_jump;

    branch_cond_eval #(
        .PSR_W(PSR_W)
    ) u_bcond (
        .branch_cond(branch_cond),
        .psr        (PSR),
        .taken      (taken)
    );

    assign timed_out     = (wait_cnt >= TIMEOUT_CNT);
    assign irq_take      = IRQ_ON && bus.irq && !in_isr;
    // JUMP drops in_isr this very cycle, so a pending irq is taken straight away.
    assign irq_take_jump = IRQ_ON && bus.irq;

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: begin
                if (bus.mem_ready)  state_nxt = S_DECODE;
                else if (timed_out) state_nxt = S_FAULT;
            end
            S_DECODE: begin
                if (op == OP_EXT) begin
                    case (op_ext)
                        SB:      state_nxt = S_ST_MEM;
                        LB:      state_nxt = S_LD_MEM;
                        JCOND:   state_nxt = taken ? S_JUMP : S_PC_UP;
                        JAL:     state_nxt = S_CALC_RLINK;
                        default: state_nxt = S_FAULT;
                    endcase
                end else if (op == RTYPE) begin
                    state_nxt = S_RTYPE_EX;
                end else if (op == BCOND) begin
                    state_nxt = taken ? S_CALC_DISP : S_PC_UP;
                end else begin
                    state_nxt = S_ITYPE_EX;
                end
            end
            S_RTYPE_EX:   state_nxt = (op_ext == CMP) ? S_PC_UP : S_WRITE;
            S_ITYPE_EX:   state_nxt = (op == CMP) ? S_PC_UP : S_WRITE;
            S_WRITE:      state_nxt = S_PC_UP;
            S_LD_MEM: begin
                if (bus.mem_ready)  state_nxt = S_LD_WB;
                else if (timed_out) state_nxt = S_FAULT;
            end
            S_LD_WB:      state_nxt = S_PC_UP;
            S_ST_MEM: begin
                if (bus.mem_ready)  state_nxt = S_PC_UP;
                else if (timed_out) state_nxt = S_FAULT;
            end
            S_CALC_RLINK: state_nxt = S_WR_RLINK_J;
            S_PC_UP, S_CALC_DISP, S_WR_RLINK_J:
                          state_nxt = irq_take ? S_IRQ_SAVE : S_FETCH;
            S_JUMP:       state_nxt = irq_take_jump ? S_IRQ_SAVE : S_FETCH;
            S_IRQ_SAVE:   state_nxt = S_IRQ_VEC;
            S_IRQ_VEC:    state_nxt = S_FETCH;
            S_FAULT:      state_nxt = S_FAULT;
            default:      state_nxt = S_FAULT;
        endcase
    end

    // wait_cnt restarts on every entry into a memory state and counts dwell cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            in_isr   <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                wait_cnt <= '0;
            else if (is_mem_state(state))
                wait_cnt <= wait_cnt + 8'd1;
            if (state == S_IRQ_VEC && IRQ_ON)
                in_isr <= 1'b1;
            else if (state == S_JUMP)
                in_isr <= 1'b0;
            if (state_nxt == S_FAULT)
                fault <= 1'b1;
        end
    end

    always_comb begin
        WD_S        = WD_RSRC;
        ALUA_S      = ALUA_REG;
        ALUB_S      = ALUB_REG;
        PC_S        = PC_SRC_REG;
        PC_EN       = 1'b0;
        REG_WR_EN   = 1'b0;
        INSTR_EN    = 1'b0;
        ALU_OUT_EN  = 1'b0;
        MEM_REG_EN  = 1'b0;
        MEM_WR_S    = 1'b0;
        MEM_S       = 1'b0;
        SE_SIGN     = 1'b1;
        PSR_EN      = 1'b0;
        wr_link     = 1'b0;
        bus.mem_req = 1'b0;
        bus.irq_ack = 1'b0;
        case (state)
            S_FETCH: begin
                MEM_S       = 1'b1;
                bus.mem_req = 1'b1;
                INSTR_EN    = bus.mem_ready;
            end
            S_RTYPE_EX: begin
                ALU_OUT_EN = 1'b1;
                PSR_EN     = 1'b1;
            end
            S_ITYPE_EX: begin
                ALUA_S     = ALUA_IMM;
                ALU_OUT_EN = 1'b1;
                PSR_EN     = 1'b1;
                SE_SIGN    = imm_sign_ext(op);
            end
            S_WRITE: begin
                WD_S      = WD_ALU;
                REG_WR_EN = 1'b1;
            end
            S_LD_MEM: begin
                bus.mem_req = 1'b1;
                MEM_REG_EN  = bus.mem_ready;
            end
            S_LD_WB: begin
                WD_S      = WD_MEM;
                REG_WR_EN = 1'b1;
            end
            S_ST_MEM: begin
                bus.mem_req = 1'b1;
                MEM_WR_S    = bus.mem_ready;
            end
            S_CALC_DISP: begin
                ALUA_S = ALUA_PC;
                ALUB_S = ALUB_DISP;
                PC_S   = PC_SRC_ALU;
                PC_EN  = 1'b1;
            end
            S_JUMP: begin
                PC_S  = PC_SRC_REG;
                PC_EN = 1'b1;
            end
            S_CALC_RLINK: begin
                ALUA_S     = ALUA_PC;
                ALUB_S     = ALUB_ONE;
                ALU_OUT_EN = 1'b1;
            end
            S_WR_RLINK_J: begin
                WD_S      = WD_ALU;
                REG_WR_EN = 1'b1;
                PC_EN     = 1'b1;
            end
            S_PC_UP: begin
                ALUA_S = ALUA_PC;
                ALUB_S = ALUB_ONE;
                PC_S   = PC_SRC_ALU;
                PC_EN  = 1'b1;
            end
            S_IRQ_SAVE: begin
                WD_S      = WD_PC;
                wr_link   = 1'b1;
                REG_WR_EN = 1'b1;
            end
            S_IRQ_VEC: begin
                PC_S        = PC_SRC_VEC;
                PC_EN       = 1'b1;
                bus.irq_ack = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
